// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shifter-sharing arbiter.
//   DATA_W / SHAMT_W : operand and shift-amount widths of the shared shifter
//   out_state_e      : state of the one-entry result register
//   sticky_of()      : OR of the operand bits that a logical right shift discards
package shift_arb_pkg;

  localparam int unsigned DATA_W  = 11;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Any amount of DATA_W or more discards every operand bit.
  function automatic logic sticky_of(input logic [DATA_W-1:0]  d,
                                     input logic [SHAMT_W-1:0] sh);
    logic [DATA_W-1:0] mask;
    if (32'(sh) >= DATA_W) return |d;
    mask = (DATA_W'(1) << sh) - DATA_W'(1);
    return |(d & mask);
  endfunction

endpackage

// File: rtl/barrelShifterRight.sv
// 11-bit logical right barrel shifter, zero fill, 5-bit shift amount.
//   in_data  : operand
//   shamt    : shift amount (11..31 yields zero)
//   out_data : in_data >> shamt
module barrelShifterRight (
  input  logic [10:0] in_data,
  input  logic [4:0]  shamt,
  output logic [10:0] out_data
);

  logic [10:0] s0, s1, s2, s3;

  always_comb begin
    s0       = shamt[0] ? {1'b0,  in_data[10:1]} : in_data;
    s1       = shamt[1] ? {2'b0,  s0[10:2]}      : s0;
    s2       = shamt[2] ? {4'b0,  s1[10:4]}      : s1;
    s3       = shamt[3] ? {8'b0,  s2[10:8]}      : s2;
    // A 16-position stage clears an 11-bit word outright.
    out_data = shamt[4] ? '0 : s3;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector (already qualified by the caller)
//   advance    : a grant was consumed this cycle; pointer moves past it
//   grant      : one-hot grant, first requester at or above the pointer
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] nxt;

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    nxt   = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        nxt        = PTR_W'((32'(idx) + 1) % NUM_REQ);
      end
    end
    ptr_d = (advance && found) ? nxt : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_req_arbiter.sv
// Shares one barrelShifterRight between NUM_REQ requesters with round-robin
// arbitration and a one-entry registered result stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_data/req_shamt  : packed operands / shift amounts, requester i at slice i
//   rsp_valid/rsp_ready : result handshake
//   rsp_data/rsp_id     : shifted result and index of its requester
//   busy                : result held or any request pending
//   rsp_sticky          : OR of shifted-out bits (only with SHIFT_STICKY_EN)
module shift_req_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       busy
`ifdef SHIFT_STICKY_EN
  ,
  output logic                       rsp_sticky
`endif
);

  out_state_e          state_q, state_d;
  logic                can_accept;
  logic                accept;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   sel_data, shifted, data_q;
  logic [SHAMT_W-1:0]  sel_shamt;
  logic [ID_W-1:0]     sel_id, id_q;

  assign can_accept = (state_q == EMPTY) || (rsp_valid && rsp_ready);
  // Gating with rst_n keeps req_ready low for the whole reset period.
  assign arb_req    = req_valid & {NUM_REQ{can_accept & rst_n}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Steer the granted requester's operands into the single shifter.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    sel_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
        sel_id    = ID_W'(i);
      end
    end
  end

  barrelShifterRight u_shifter (
    .in_data  (sel_data),
    .shamt    (sel_shamt),
    .out_data (shifted)
  );

  always_comb begin
    state_d = state_q;
    if (accept)                            state_d = FULL;
    else if (state_q == FULL && rsp_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= shifted;
        id_q   <= sel_id;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = rsp_valid | (|req_valid);

`ifdef SHIFT_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sticky_q <= 1'b0;
    else if (accept) sticky_q <= sticky_of(sel_data, sel_shamt);
  end

  assign rsp_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_shift_req_arbiter.sv
module tb_shift_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 11;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_shamt;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;
`ifdef SHIFT_STICKY_EN
  logic            rsp_sticky;
`endif

  shift_req_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef SHIFT_STICKY_EN
    ,
    .rsp_sticky(rsp_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Requester-side intent and reference model state.
  bit          v[N];
  int unsigned d[N];
  int unsigned s[N];
  bit          auto_clear;
  int          m_ptr;
  bit          m_full;
  int unsigned m_data;
  int unsigned m_id;
  bit          m_sticky;
  int          grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = v[i];
      req_data[i*DW +: DW]   = DW'(d[i]);
      req_shamt[i*SW +: SW]  = SW'(s[i]);
    end
  endtask

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_v();
    bit r;
    r = 0;
    for (int i = 0; i < N; i++) r |= v[i];
    return r;
  endfunction

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_data = 0; m_id = 0; m_sticky = 0;
  endtask

  task automatic check_outputs();
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
    chk("rsp_data",  {21'd0, rsp_data},  m_data);
    chk("rsp_id",    {30'd0, rsp_id},    m_id);
`ifdef SHIFT_STICKY_EN
    chk("rsp_sticky", {31'd0, rsp_sticky}, {31'd0, m_sticky});
`endif
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic step();
    int           g;
    logic [N-1:0] er;
    apply();
    #3;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, er});
    chk("busy", {31'd0, busy}, {31'd0, (m_full || any_v())});
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (g >= 0) begin
        m_data   = (d[g] >> s[g]) & 32'h7FF;
        m_sticky = (s[g] >= DW) ? (d[g] != 0) : ((d[g] % (1 << s[g])) != 0);
        m_id     = g;
        m_full   = 1;
        m_ptr    = (g + 1) % N;
        grant_log.push_back(g);
        if (auto_clear) v[g] = 0;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
    end
    check_outputs();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin v[i] = 0; d[i] = 0; s[i] = 0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_async_data",  {21'd0, rsp_data},  32'd0);
    step();
    rst_n = 1'b1;
  endtask

  int unsigned bd_d[4]   = '{32'h5A3, 32'h400, 32'h7FF, 32'h123};
  int unsigned bd_s[4]   = '{0, 10, 11, 31};
  int unsigned bd_exp[4] = '{32'h5A3, 32'h001, 32'h000, 32'h000};
  int          fair_exp[6] = '{0, 1, 2, 3, 0, 1};
  int          skip_exp[3] = '{3, 1, 3};

  initial begin
    logic [DW-1:0] held_data;
    logic [1:0]    held_id;
    int            base;

    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    auto_clear = 1;
    clear_reqs();
    model_reset();
    apply();
    @(posedge clk);
    #1;
    check_outputs();

    // Request pending during reset must not be accepted.
    v[0] = 1; d[0] = 32'h7FF; s[0] = 3;
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;

    // Single request.
    step();
    chk("single_data", {21'd0, rsp_data}, 32'h0FF);
    chk("single_id",   {30'd0, rsp_id},   32'd0);
    step();

    // Boundary shift amounts through requester 0.
    for (int t = 0; t < 4; t++) begin
      v[0] = 1; d[0] = bd_d[t]; s[0] = bd_s[t];
      step();
      chk("boundary_data", {21'd0, rsp_data}, bd_exp[t]);
    end
    step();

    // Fairness with all requesters valid from a fresh pointer.
    do_reset();
    auto_clear = 0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1; d[i] = $urandom_range(0, 2047); s[i] = $urandom_range(0, 31);
    end
    grant_log.delete();
    for (int k = 0; k < 6; k++) step();
    chk("fair_count", grant_log.size(), 32'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk("fair_order", grant_log[k], fair_exp[k]);

    // Backpressure: result held, no grants, pointer frozen.
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_data_stable", {21'd0, rsp_data}, {21'd0, held_data});
      chk("bp_id_stable",   {30'd0, rsp_id},   {30'd0, held_id});
    end
    grant_log.delete();
    rsp_ready = 1'b1;
    step();
    chk("bp_resume_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd2);

    // Pointer wrap and skip: requester 1 alone moves pointer to 2.
    clear_reqs();
    v[1] = 1; d[1] = 32'h3C5; s[1] = 2;
    step();
    v[3] = 1; d[3] = 32'h1F0; s[3] = 4;
    grant_log.delete();
    for (int k = 0; k < 3; k++) step();
    chk("skip_count", grant_log.size(), 32'd3);
    for (int k = 0; k < 3 && k < grant_log.size(); k++)
      chk("skip_order", grant_log[k], skip_exp[k]);

    // Reset while FULL discards the held result.
    rsp_ready = 1'b0;
    step();
    chk("pre_reset_full", {31'd0, rsp_valid}, 32'd1);
    do_reset();
    clear_reqs();
    rsp_ready = 1'b1;
    step();
    chk("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < N; i++) begin
      v[i] = 1; d[i] = $urandom_range(0, 2047); s[i] = $urandom_range(0, 31);
    end
    grant_log.delete();
    step();
    chk("post_reset_prio", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);

    // Randomized traffic against the model.
    clear_reqs();
    auto_clear = 1;
    base = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1;
          d[i] = $urandom_range(0, 2047);
          s[i] = $urandom_range(0, 31);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    clear_reqs();
    rsp_ready = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_req_arbiter.md
Name: shift_req_arbiter

Overview:
- Shares one instance of the 11-bit logical right barrel shifter (barrelShifterRight) between NUM_REQ requesters, e.g. the FP-add exponent-alignment path and the normalisation path.
- Round-robin arbitration, valid/ready handshake on every requester and on the single response channel, one-entry registered output stage.
- Each result carries the index of the requester that produced it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 11, operand width; fixed by the shifter datapath.
- SHAMT_W, 5, shift-amount width; fixed by the shifter datapath.
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*DATA_W  operands, requester i at [i*DATA_W +: DATA_W].
- req_shamt  in  NUM_REQ*SHAMT_W  shift amounts, requester i at [i*SHAMT_W +: SHAMT_W].
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_W  shifted result.
- rsp_id  out  ID_W  index of the requester that produced rsp_data.
- busy  out  1  high when rsp_valid is high or any req_valid is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready=0 while reset is asserted.
- Output register FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) OR (rsp_valid AND rsp_ready). Simultaneous drain and accept is allowed, giving back-to-back throughput of one result per cycle.
- Grant logic (combinational):
  - When can_accept is high, grant goes to the first requester with req_valid high, searching from the pointer upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted requester only. All req_ready are 0 when can_accept is 0 or no request is pending.
  - req_ready may depend combinationally on req_valid and rsp_ready. It must never depend on req_data or req_shamt.
- Handshake at a rising edge where req_valid[g] AND req_ready[g]:
  - req_data[g] and req_shamt[g] are steered through the shared shifter.
  - The result is registered into rsp_data; rsp_id=g; state=FULL.
  - Pointer updates to (g+1) mod NUM_REQ.
  - Latency: result visible the cycle after acceptance.
- Drain without new accept (rsp_valid AND rsp_ready, no grant): state goes to EMPTY. rsp_data and rsp_id hold their last values.
- FULL with rsp_ready=0:
  - rsp_data and rsp_id are held stable.
  - req_ready stays all zero.
  - Pointer does not move.
- Requesters must hold req_valid, req_data and req_shamt stable until accepted; the block does not check this.
- Arithmetic: logical right shift with zero fill. shamt >= DATA_W (11..31) gives rsp_data=0.
- Pointer wraps from NUM_REQ-1 to 0. A lone requester is granted every accepting cycle.
- Reset mid-operation discards any held result; no response is issued for it.

Optional Feature:
- Macro: SHIFT_STICKY_EN.
- When defined:
  - Extra output port rsp_sticky (out, 1).
  - Registered alongside rsp_data as the OR of all operand bits shifted out: |(data & ((1<<shamt)-1)) for shamt < DATA_W, and |data for shamt >= DATA_W.
  - Reset value 0.
  - Used for FP rounding.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package shift_arb_pkg holds:
  - constants DATA_W=11 and SHAMT_W=5;
  - the state encoding typedef (EMPTY, FULL).
- Natural sub-module: rr_arbiter (NUM_REQ-wide round-robin grant with pointer register, inputs clk/rst_n/req/advance, output one-hot grant).
- The shifter itself is the existing barrelShifterRight, instantiated once; no copy of it is made.

Test Plan:
- Single request: req_valid[0]=1, data=11'h7FF, shamt=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=11'h0FF, rsp_id=0, sticky=1 if enabled.
- Fairness: all four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles; one result per cycle.
- Backpressure: FULL with rsp_ready=0 for 5 cycles while req_valid=4'b1111 -> req_ready=0, rsp_data and rsp_id stable; after rsp_ready=1, the next grant goes to the pointer position.
- Boundary shifts: shamt=0 -> rsp_data=data; shamt=10 on 11'h400 -> 11'h001; shamt=11 and shamt=31 -> rsp_data=0 (sticky=|data if enabled).
- Pointer wrap and skip: only requesters 1 and 3 valid, pointer at 2 -> grant 3, then 1, then 3.
- Reset mid-operation: assert rst_n low asynchronously while FULL -> rsp_valid=0 immediately; after release, requester 0 has priority and no stale response appears.
